// File: rtl/rd_act_sequencer_if.sv
// Purpose: bundles the per-channel request/response lines of rd_act_sequencer.
//  Ports (all CH bits wide):
//   en_i    request -> sequencer  start/hold request (level)
//   done_i  request -> sequencer  completion/abort (level)
//   rd_o    sequencer -> engines  read strobe
//   act_o   sequencer -> engines  activate
//   busy_o  sequencer -> engines  channel not idle
//   abort_o sequencer -> engines  1-cycle abort pulse
//  master: front-end / bench side, slave: sequencer side.
interface rd_act_if #(
   parameter int CH = 4
);
   logic [CH-1:0] en_i;
   logic [CH-1:0] done_i;
   logic [CH-1:0] rd_o;
   logic [CH-1:0] act_o;
   logic [CH-1:0] busy_o;
   logic [CH-1:0] abort_o;

   modport master (
      output en_i, done_i,
      input  rd_o, act_o, busy_o, abort_o
   );

   modport slave (
      input  en_i, done_i,
      output rd_o, act_o, busy_o, abort_o
   );
endinterface

// File: rtl/rd_act_sequencer.sv
// Purpose: multi-channel read/activate sequencer. A held enable raises rd
//  after RD_LAT edges and act a further ACT_LAT edges later; done parks the
//  channel until its enable is released.
// Ports:
//  clk    in  single clock, posedge
//  rst_n  in  synchronous active-low reset
//  bus    rd_act_if.slave: en_i/done_i in, rd_o/act_o/busy_o/abort_o out
// Build option: RDACT_RR_ARB_EN adds a round-robin arbiter so that at most
//  one channel is in ACT at a time.
//
// state    | meaning
// S_IDLE   | waiting for en
// S_RD_DLY | counting RD_LAT before rd
// S_RD     | rd high, counting ACT_LAT (or waiting for grant)
// S_ACT    | rd and act high
// S_HOLD   | done taken, waiting for en release
module rd_act_sequencer #(
   parameter int CH      = 4,
   parameter int RD_LAT  = 1,
   parameter int ACT_LAT = 1,
   parameter int CNT_W   = 4
) (
   input logic    clk,
   input logic    rst_n,
   rd_act_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_DLY,
      S_RD,
      S_ACT,
      S_HOLD
   } state_t;

   state_t           r_state     [CH];
   state_t           w_state_nxt [CH];
   logic [CNT_W-1:0] r_cnt       [CH];
   logic [CNT_W-1:0] w_cnt_nxt   [CH];
   logic [CH-1:0]    r_abort;
   logic [CH-1:0]    w_abort_nxt;

`ifdef RDACT_RR_ARB_EN
   localparam int PTR_W = (CH > 1) ? $clog2(CH) : 1;

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_ptr_nxt;
   logic [CH-1:0]    w_ready;
   logic [CH-1:0]    w_gnt;
   logic             w_any_act;
   logic             w_found;

   function automatic logic [PTR_W-1:0] wrap_idx(input int v);
      return PTR_W'(v % CH);
   endfunction

   // Grants are issued only when no channel is registered in ACT, which
   // leaves one act-free cycle between consecutive owners.
   always_comb begin
      w_gnt     = '0;
      w_ptr_nxt = r_ptr;
      w_any_act = 1'b0;
      w_found   = 1'b0;
      w_ready   = '0;
      for (int c = 0; c < CH; c++) begin
         if (r_state[c] == S_ACT) w_any_act = 1'b1;
         w_ready[c] = (r_state[c] == S_RD) && (r_cnt[c] == '0) &&
                      bus.en_i[c] && !bus.done_i[c];
      end
      if (!w_any_act) begin
         for (int k = 0; k < CH; k++) begin
            if (!w_found && w_ready[wrap_idx(int'(r_ptr) + k)]) begin
               w_found                           = 1'b1;
               w_gnt[wrap_idx(int'(r_ptr) + k)]  = 1'b1;
               w_ptr_nxt = wrap_idx(int'(r_ptr) + k + 1);
            end
         end
      end
   end
`endif

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         w_state_nxt[c] = r_state[c];
         w_cnt_nxt[c]   = r_cnt[c];
         w_abort_nxt[c] = 1'b0;
         case (r_state[c])
            S_IDLE: begin
               if (bus.en_i[c]) begin
                  w_state_nxt[c] = S_RD_DLY;
                  w_cnt_nxt[c]   = CNT_W'(RD_LAT - 1);
               end
            end
            S_RD_DLY, S_RD: begin
               if (bus.done_i[c]) begin
                  w_abort_nxt[c] = 1'b1;
                  w_state_nxt[c] = bus.en_i[c] ? S_HOLD : S_IDLE;
               end else if (!bus.en_i[c]) begin
                  w_state_nxt[c] = S_IDLE;
               end else if (r_cnt[c] != '0) begin
                  w_cnt_nxt[c] = r_cnt[c] - CNT_W'(1);
               end else if (r_state[c] == S_RD_DLY) begin
                  w_state_nxt[c] = S_RD;
                  w_cnt_nxt[c]   = CNT_W'(ACT_LAT - 1);
               end else begin
`ifdef RDACT_RR_ARB_EN
                  if (w_gnt[c]) w_state_nxt[c] = S_ACT;
`else
                  w_state_nxt[c] = S_ACT;
`endif
               end
            end
            S_ACT: begin
               if (bus.done_i[c])
                  w_state_nxt[c] = bus.en_i[c] ? S_HOLD : S_IDLE;
               else if (!bus.en_i[c])
                  w_state_nxt[c] = S_IDLE;
            end
            S_HOLD: begin
               if (!bus.en_i[c]) w_state_nxt[c] = S_IDLE;
            end
            default: w_state_nxt[c] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            r_state[c] <= S_IDLE;
            r_cnt[c]   <= '0;
         end
         r_abort <= '0;
`ifdef RDACT_RR_ARB_EN
         r_ptr   <= '0;
`endif
      end else begin
         for (int c = 0; c < CH; c++) begin
            r_state[c] <= w_state_nxt[c];
            r_cnt[c]   <= w_cnt_nxt[c];
         end
         r_abort <= w_abort_nxt;
`ifdef RDACT_RR_ARB_EN
         r_ptr   <= w_ptr_nxt;
`endif
      end
   end

   always_comb begin
      bus.rd_o   = '0;
      bus.act_o  = '0;
      bus.busy_o = '0;
      for (int c = 0; c < CH; c++) begin
         bus.rd_o[c]   = (r_state[c] == S_RD) || (r_state[c] == S_ACT);
         bus.act_o[c]  = (r_state[c] == S_ACT);
         bus.busy_o[c] = (r_state[c] != S_IDLE);
      end
   end

   assign bus.abort_o = r_abort;

endmodule

// File: tb/tb_rd_act_sequencer.sv
module tb_rd_act_sequencer;
   localparam int CH      = 4;
   localparam int RD_LAT  = 2;
   localparam int ACT_LAT = 3;
   localparam int CNT_W   = 4;
   localparam int L       = RD_LAT + ACT_LAT;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rd_act_if #(.CH(CH)) u_if ();

   rd_act_sequencer #(
      .CH(CH), .RD_LAT(RD_LAT), .ACT_LAT(ACT_LAT), .CNT_W(CNT_W)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (u_if)
   );

   typedef struct {
      logic [CH-1:0] rd;
      logic [CH-1:0] act;
      logic [CH-1:0] busy;
      logic [CH-1:0] abort;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: each channel is "running" for t edges since its start
   // edge, "parked" after a done, or off. rd/act follow from t alone; in the
   // arbitrated build act follows from ownership instead.
   bit m_run  [CH];
   bit m_park [CH];
   bit m_own  [CH];
   int m_t    [CH];
   int m_ptr;

   initial begin
      exp_t          e;
      logic [CH-1:0] en, dn;
      int            gnt;
      bit            in_act, any_own;
      for (int c = 0; c < CH; c++) begin
         m_run[c] = 0; m_park[c] = 0; m_own[c] = 0; m_t[c] = 0;
      end
      m_ptr = 0;
      forever begin
         @(posedge clk);
         en = u_if.en_i;
         dn = u_if.done_i;
         e.abort = '0;
         if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
               m_run[c] = 0; m_park[c] = 0; m_own[c] = 0; m_t[c] = 0;
            end
            m_ptr = 0;
         end else begin
            gnt = -1;
`ifdef RDACT_RR_ARB_EN
            any_own = 0;
            for (int c = 0; c < CH; c++) if (m_own[c]) any_own = 1;
            if (!any_own) begin
               for (int k = 0; k < CH; k++) begin
                  int idx;
                  idx = (m_ptr + k) % CH;
                  if (gnt < 0 && m_run[idx] && !m_own[idx] && m_t[idx] >= L - 1 &&
                      en[idx] && !dn[idx]) gnt = idx;
               end
               if (gnt >= 0) m_ptr = (gnt + 1) % CH;
            end
`endif
            for (int c = 0; c < CH; c++) begin
               if (m_park[c]) begin
                  if (!en[c]) m_park[c] = 0;
               end else if (m_run[c]) begin
`ifdef RDACT_RR_ARB_EN
                  in_act = m_own[c];
`else
                  in_act = (m_t[c] >= L);
`endif
                  if (dn[c]) begin
                     e.abort[c] = !in_act;
                     m_run[c]   = 0;
                     m_own[c]   = 0;
                     m_park[c]  = en[c];
                  end else if (!en[c]) begin
                     m_run[c] = 0;
                     m_own[c] = 0;
                  end else begin
                     m_t[c] = (m_t[c] + 1 > L + 1) ? L + 1 : m_t[c] + 1;
                     if (c == gnt) m_own[c] = 1;
                  end
               end else if (en[c]) begin
                  m_run[c] = 1;
                  m_t[c]   = 0;
               end
            end
         end
         for (int c = 0; c < CH; c++) begin
            e.rd[c]   = m_run[c] && (m_t[c] >= RD_LAT);
`ifdef RDACT_RR_ARB_EN
            e.act[c]  = m_run[c] && m_own[c];
`else
            e.act[c]  = m_run[c] && (m_t[c] >= L);
`endif
            e.busy[c] = m_run[c] || m_park[c];
         end
         exp_q.push_back(e);
      end
   end

   task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s @%0t: got %b expected %b", name, $time, got, want);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_o",    u_if.rd_o,    e.rd);
            chk("act_o",   u_if.act_o,   e.act);
            chk("busy_o",  u_if.busy_o,  e.busy);
            chk("abort_o", u_if.abort_o, e.abort);
`ifdef RDACT_RR_ARB_EN
            n_tests++;
            if ($countones(u_if.act_o) > 1) begin
               n_fail++;
               $display("FAIL act_onehot @%0t: got %b required at most one bit", $time, u_if.act_o);
            end
`endif
         end
      end
   end

   task automatic drive(input logic rst, input logic [CH-1:0] en, input logic [CH-1:0] dn);
      @(negedge clk);
      #1;
      rst_n       = rst;
      u_if.en_i   = en;
      u_if.done_i = dn;
   endtask

   initial begin
      logic [CH-1:0] en, dn;
      bit            drained;
      u_if.en_i   = '0;
      u_if.done_i = '0;
      repeat (3) drive(1'b0, '0, '0);
      // single channel start, done in ACT, release, re-arm
      repeat (8) drive(1'b1, 4'b0001, '0);
      drive(1'b1, 4'b0001, 4'b0001);
      repeat (2) drive(1'b1, 4'b0001, '0);
      drive(1'b1, 4'b0000, '0);
      repeat (4) drive(1'b1, 4'b0001, '0);
      // early done on ch1 -> abort before rd
      drive(1'b1, 4'b0010, '0);
      drive(1'b1, 4'b0010, 4'b0010);
      repeat (3) drive(1'b1, 4'b0010, '0);
      drive(1'b1, 4'b0000, '0);
      // all channels into ACT, reset mid-operation, resume
      repeat (10) drive(1'b1, 4'hF, '0);
      drive(1'b0, 4'hF, '0);
      repeat (10) drive(1'b1, 4'hF, '0);
      // done and en-low together, pre-ACT and in ACT
      drive(1'b1, 4'b1011, 4'b0100);
      repeat (3) drive(1'b1, 4'b1011, '0);
      drive(1'b1, 4'b0000, 4'b0001);
      repeat (2) drive(1'b1, 4'b0000, '0);
      en = '0;
      for (int n = 0; n < 4000; n++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 9) == 0) en[c] = ~en[c];
            dn[c] = ($urandom_range(0, 11) == 0);
         end
         drive(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, en, dn);
      end
      drive(1'b1, '0, '0);
      drained = 0;
      for (int i = 0; i < 10 && !drained; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) drained = 1;
      end
      n_tests++;
      if (!drained) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
